// File: rtl/aes_enc_hs.sv
// Iterative AES-128 encryptor. It computes one round per clock and expands
// the key on the fly. Input and output use valid/ready handshakes.
// The round-10 key and the rcon that follows it are exported so that a
// paired decryptor can start its reverse key schedule from them.

// Forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the inverse of a for a != 0; it maps 0 to 0, which the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] sub(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign s_o = sub(a_i);
endmodule

// MixColumns for one 32-bit column. Bits [31:24] hold row 0.
module aes_mixcol_word (
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_i[31:24];
   assign a1 = col_i[23:16];
   assign a2 = col_i[15:8];
   assign a3 = col_i[7:0];

   assign col_o[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
   assign col_o[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
   assign col_o[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
   assign col_o[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

// One forward key-schedule step: rk_n plus rcon_(n+1) gives rk_(n+1).
module aes_key_step (
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] key_o
);
   logic [31:0] rot;
   logic [31:0] sub;
   logic [31:0] t;
   logic [31:0] n0, n1, n2, n3;

   assign rot = {key_i[23:0], key_i[31:24]};

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_sb
         aes_sbox u_sb (.a_i(rot[8*g +: 8]), .s_o(sub[8*g +: 8]));
      end
   endgenerate

   assign t  = sub ^ {rcon_i, 24'h000000};
   assign n0 = key_i[127:96] ^ t;
   assign n1 = key_i[95:64]  ^ n0;
   assign n2 = key_i[63:32]  ^ n1;
   assign n3 = key_i[31:0]   ^ n2;
   assign key_o = {n0, n1, n2, n3};
endmodule

module aes_enc_hs (
   input  logic         clk,
   input  logic         reset,
   input  logic         data_v_i,
   output logic         data_rdy_o,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic         res_v_o,
   input  logic         res_rdy_i,
   output logic [127:0] res_o,
   output logic [127:0] key_last_o,
   output logic [7:0]   rcon_last_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       st_q, st_d;
   logic         rdy_q, vld_q;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] key_q, key_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] klast_q, klast_d;
   logic [7:0]   rclast_q, rclast_d;

   logic [127:0] sb, sr, mc, rnd;
   logic [127:0] ks_key, ks_out;
   logic [7:0]   ks_rcon;
   logic         accept;

   assign accept = (st_q == IDLE) && data_v_i;

   // In IDLE the key schedule is seeded from the incoming key with rcon 0x01.
   // After that it steps the stored round key.
   assign ks_key  = (st_q == IDLE) ? key_i : key_q;
   assign ks_rcon = (st_q == IDLE) ? 8'h01 : rcon_q;

   aes_key_step u_ks (.key_i(ks_key), .rcon_i(ks_rcon), .key_o(ks_out));

   // Byte (row r, col c) lives at bits [127-8*(4c+r) -: 8].
   // ShiftRows rotates row r left by r columns.
   genvar r, c;
   generate
      for (c = 0; c < 4; c++) begin : g_col
         for (r = 0; r < 4; r++) begin : g_row
            aes_sbox u_sb (.a_i(blk_q[127-8*(4*c+r) -: 8]),
                           .s_o(sb[127-8*(4*c+r) -: 8]));
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
         end
         aes_mixcol_word u_mc (.col_i(sr[127-32*c -: 32]), .col_o(mc[127-32*c -: 32]));
      end
   endgenerate

   // The final round skips MixColumns.
   assign rnd = ((cnt_q == 4'd10) ? sr : mc) ^ key_q;

   // FSM next state: accept in IDLE, run rounds 1..10, then hold until taken.
   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE: if (data_v_i) st_d = RUN;
         RUN: begin
            if (cnt_q == 4'd10)                        st_d = DONE;
            else if (cnt_q == 4'd0 || cnt_q > 4'd10)   st_d = IDLE;
         end
         DONE: if (res_rdy_i) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   // State register plus registered handshake flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q  <= IDLE;
         rdy_q <= 1'b1;
         vld_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         rdy_q <= (st_d == IDLE);
         vld_q <= (st_d == DONE);
      end
   end

   // Datapath next values: load on accept, then one round per RUN cycle.
   always_comb begin
      blk_d    = blk_q;
      key_d    = key_q;
      rcon_d   = rcon_q;
      cnt_d    = cnt_q;
      klast_d  = klast_q;
      rclast_d = rclast_q;
      if (accept) begin
         blk_d  = data_i ^ key_i;
         key_d  = ks_out;
         rcon_d = 8'h02;
         cnt_d  = 4'd1;
      end else if (st_q == RUN) begin
         if (cnt_q >= 4'd1 && cnt_q <= 4'd9) begin
            blk_d  = rnd;
            key_d  = ks_out;
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            cnt_d  = cnt_q + 4'd1;
         end else if (cnt_q == 4'd10) begin
            blk_d    = rnd;
            klast_d  = key_q;
            rclast_d = 8'h36;
            cnt_d    = 4'd0;
         end else begin
            cnt_d = 4'd0;
         end
      end
   end

   // Datapath registers. They are reset too, so the outputs never show X.
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_q    <= '0;
         key_q    <= '0;
         rcon_q   <= '0;
         cnt_q    <= '0;
         klast_q  <= '0;
         rclast_q <= '0;
      end else begin
         blk_q    <= blk_d;
         key_q    <= key_d;
         rcon_q   <= rcon_d;
         cnt_q    <= cnt_d;
         klast_q  <= klast_d;
         rclast_q <= rclast_d;
      end
   end

   assign data_rdy_o  = rdy_q;
   assign res_v_o     = vld_q;
   assign res_o       = blk_q;
   assign key_last_o  = klast_q;
   assign rcon_last_o = rclast_q;
endmodule

// File: tb/tb_aes_enc_hs.sv
// Directed bench for aes_enc_hs: FIPS-197 vectors, backpressure,
// back-to-back accepts and reset in the middle of a block.
module tb_aes_enc_hs;
   logic         clk = 1'b0;
   logic         reset;
   logic         data_v_i;
   logic         data_rdy_o;
   logic [127:0] data_i;
   logic [127:0] key_i;
   logic         res_v_o;
   logic         res_rdy_i;
   logic [127:0] res_o;
   logic [127:0] key_last_o;
   logic [7:0]   rcon_last_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc[$];

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      logic [127:0] kl;
      bit           chk_kl;
      bit           bp;
   } vec_t;

   vec_t vecs[3];

   aes_enc_hs dut (
      .clk(clk), .reset(reset), .data_v_i(data_v_i), .data_rdy_o(data_rdy_o),
      .data_i(data_i), .key_i(key_i), .res_v_o(res_v_o), .res_rdy_i(res_rdy_i),
      .res_o(res_o), .key_last_o(key_last_o), .rcon_last_o(rcon_last_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && data_v_i && data_rdy_o) acc_cyc.push_back(cyc);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!data_rdy_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_wait", 128'(data_rdy_o), 128'd1);
   endtask

   task automatic wait_res(input string nm);
      int lat = 0;
      while (!res_v_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 128'(lat), 128'd10);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      wait_rdy();
      data_v_i  = 1'b1;
      key_i     = v.key;
      data_i    = v.pt;
      res_rdy_i = !v.bp;
      @(negedge clk);
      data_v_i = 1'b0;
      data_i   = {$urandom, $urandom, $urandom, $urandom};
      key_i    = {$urandom, $urandom, $urandom, $urandom};
      chk("rdy_in_run", 128'(data_rdy_o), 128'd0);
      wait_res("vec");
      chk("ct", res_o, v.ct);
      if (v.chk_kl) chk("key_last", key_last_o, v.kl);
      chk("rcon_last", 128'(rcon_last_o), 128'h36);
      if (v.bp) begin
         for (int i = 0; i < 7; i++) begin
            data_v_i = 1'($urandom_range(0, 1));
            data_i   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_vld", 128'(res_v_o), 128'd1);
            chk("bp_res", res_o, v.ct);
            chk("bp_rdy", 128'(data_rdy_o), 128'd0);
         end
         data_v_i  = 1'b0;
         res_rdy_i = 1'b1;
      end
      @(negedge clk);
      chk("taken_vld", 128'(res_v_o), 128'd0);
      chk("taken_rdy", 128'(data_rdy_o), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int base;
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1, 1'b0};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b1};
      vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0, 1'b0};

      reset = 1'b1; data_v_i = 1'b0; data_i = '0; key_i = '0; res_rdy_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 128'(data_rdy_o), 128'd1);
      chk("rst_vld", 128'(res_v_o), 128'd0);
      chk("rst_res", res_o, 128'd0);
      chk("rst_klast", key_last_o, 128'd0);
      chk("rst_rclast", 128'(rcon_last_o), 128'd0);
      reset = 1'b0;

      for (int i = 0; i < 3; i++) run_vec(vecs[i]);

      // Back-to-back: data_v_i stays high across the B and C.1 blocks.
      @(negedge clk);
      wait_rdy();
      base = acc_cyc.size();
      data_v_i = 1'b1; key_i = vecs[1].key; data_i = vecs[1].pt; res_rdy_i = 1'b1;
      @(negedge clk);
      key_i = vecs[0].key; data_i = vecs[0].pt;
      wait_res("b2b_first");
      chk("b2b_ct0", res_o, vecs[1].ct);
      @(negedge clk);
      @(negedge clk);
      data_v_i = 1'b0;
      chk("b2b_rdy_low", 128'(data_rdy_o), 128'd0);
      wait_res("b2b_second");
      chk("b2b_ct1", res_o, vecs[0].ct);
      chk("b2b_accepts", 128'(acc_cyc.size() - base), 128'd2);
      if (acc_cyc.size() - base == 2)
         chk("b2b_interval", 128'(acc_cyc[base+1] - acc_cyc[base]), 128'd12);
      @(negedge clk);

      // Reset during round 5 discards the block.
      wait_rdy();
      data_v_i = 1'b1; key_i = vecs[0].key; data_i = vecs[0].pt;
      @(negedge clk);
      data_v_i = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_vld", 128'(res_v_o), 128'd0);
      chk("midrst_rdy", 128'(data_rdy_o), 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (res_v_o) seen = 1'b1;
      end
      chk("midrst_no_vld", 128'(seen), 128'd0);
      run_vec(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aes_enc_hs.md
Name: aes_enc_hs

Overview:
- Iterative AES-128 encryptor, one round per clock, with on-the-fly forward key expansion.
- Input and output sides use valid/ready handshakes; the result is held under backpressure.
- Also exports the final (round-10) round key and the rcon value that follows it. The decryptor uses these as its encoded-key input and initial rcon, so this block pairs with the decryption path on the opposite side of the link.
- Instantiates the existing forward S-box, MixColumns-word and key-schedule leaf cells.

Parameters:
- None. Fixed to AES-128: 128-bit block, 128-bit key, 10 rounds.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_v_i  in  1  plaintext/key valid.
- data_rdy_o  out  1  block can accept a new block.
- data_i  in  128  plaintext; [127:120] is FIPS byte 0, column-major.
- key_i  in  128  cipher key, same byte order.
- res_v_o  out  1  ciphertext valid.
- res_rdy_i  in  1  downstream accepts the result.
- res_o  out  128  ciphertext.
- key_last_o  out  128  round key 10, valid while res_v_o=1.
- rcon_last_o  out  8  rcon following round 10 (0x36), valid while res_v_o=1.

Behaviour:
- Reset values: state=IDLE, round counter=0, data_rdy_o=1, res_v_o=0. res_o, key_last_o and rcon_last_o are 0 at reset. Datapath registers are reset as well, so outputs never show X.
- Accept: happens when data_v_i & data_rdy_o are both high on a rising edge (cycle 0). On that edge:
  - state <= data_i ^ key_i (initial AddRoundKey);
  - key register <= round key 1;
  - rcon register <= 0x02;
  - counter <= 1;
  - FSM -> RUN.
- Rcon seeding: the key schedule is fed key_i and rcon 0x01 in the accept cycle.
- RUN, counter n = 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_n. The key register advances to rk_(n+1), and rcon is doubled in GF(2^8) (0x80 -> 0x1B).
- RUN, counter 10: state <= ShiftRows(SubBytes(state)) ^ rk_10, with MixColumns bypassed. key_last register <= rk_10 and rcon_last <= 0x36. FSM -> DONE.
- Operation order: SubBytes before ShiftRows; both are bytewise and permutation-only, so the order is interchangeable.
- Latency: res_v_o rises exactly 10 cycles after the accept edge.
- DONE:
  - res_v_o=1; res_o, key_last_o and rcon_last_o are stable.
  - When res_rdy_i=1: FSM -> IDLE and res_v_o=0 next cycle.
  - While res_rdy_i=0: hold indefinitely; all outputs are unchanged.
- data_rdy_o is 1 only in IDLE. There is no overlap: no new accept is possible in RUN or DONE. A data_v_i seen in RUN or DONE is ignored, and the source must hold it.
- Back-to-back operation: when the result is taken in DONE with data_v_i already high, the next accept occurs on the cycle after the IDLE transition. The minimum accept-to-accept interval is 12 cycles with res_rdy_i tied high.
- Output timing: res_v_o and data_rdy_o are registered decodes of FSM state, with no combinational path from inputs.
- Input sampling: data_i and key_i are sampled only on the accept edge and may change freely afterwards.
- Reset mid-operation: reset in RUN or DONE returns to IDLE next cycle. res_v_o=0 and data_rdy_o=1, and the partial result is discarded. Reset has priority over accept.
- Counter: 4-bit; values 11–15 are unreachable. If reached, the FSM returns to IDLE with res_v_o=0.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, res_rdy_i=1.
  - Required: res_o=69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after accept; key_last_o=13111d7fe3944a17f307a78b4d2b30c5; rcon_last_o=36.
- FIPS-197 Appendix B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: res_o=3925841d02dc09fbdc118597196a0b32; key_last_o=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - Stimulus: hold res_rdy_i=0 for 7 cycles after res_v_o rises, and toggle data_i/data_v_i meanwhile.
  - Required: res_v_o stays 1 and res_o is unchanged; data_rdy_o=0; release gives a single-cycle handshake and then data_rdy_o=1.
- Back-to-back:
  - Stimulus: hold data_v_i=1 continuously with the B then C.1 vectors, res_rdy_i=1.
  - Required: accepts 12 cycles apart; both ciphertexts correct and in order.
- Reset mid-operation:
  - Stimulus: assert reset at round 5, then deassert and issue the C.1 vector.
  - Required: res_v_o never asserts for the aborted block; the C.1 result is correct.
- Loopback into the decryptor:
  - Stimulus: feed res_o, key_last_o and rcon_last_o into the decryption block.
  - Required: the decrypted result equals the original plaintext for 1000 random key/plaintext pairs.
